case_lane_counter: RTL



---
 rtl/case_lane_pkg.sv | 31 +++
 rtl/case_lane_cell.sv | 76 +++++++
 rtl/case_lane_counter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/case_lane_pkg.sv
// Shared types and field positions for the case_lane_counter command bank.
package case_lane_pkg;

  localparam int OP_LSB   = 0;
  localparam int LANE_LSB = 4;
  localparam int OPND_LSB = 8;
  localparam int OP_W     = 4;
  localparam int LANE_W   = 4;
  localparam int OPND_W   = 8;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_CLR  = 4'd1,
    OP_INC  = 4'd2,
    OP_DEC  = 4'd3,
    OP_LOAD = 4'd4,
    OP_ADD  = 4'd5,
    OP_READ = 4'd6
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op <= 4'd6);
  endfunction

endpackage

// File: rtl/case_lane_cell.sv
// One counter lane: computes the post-operation value and commits it on we.
// Clamping arithmetic is enabled by CASE_LANE_SAT_EN; otherwise it wraps.
module case_lane_cell
  import case_lane_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  op,
  input  logic [CNT_W-1:0] operand,
  input  logic             we,
  output logic [CNT_W-1:0] next_count,
  output logic             sat
);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] next_s;
  logic [CNT_W:0]   sum_s;
  logic             sat_s;

  // Next value and clamp flag for the captured opcode
  always_comb begin
    next_s = count_r;
    sat_s  = 1'b0;
    sum_s  = {1'b0, count_r} + {1'b0, operand};
    case (op)
      OP_CLR:  next_s = '0;
      OP_LOAD: next_s = operand;
`ifdef CASE_LANE_SAT_EN
      OP_INC: begin
        if (count_r == '1) begin
          next_s = count_r;
          sat_s  = 1'b1;
        end else begin
          next_s = count_r + CNT_W'(1'b1);
        end
      end
      OP_DEC: begin
        if (count_r == '0) begin
          next_s = count_r;
          sat_s  = 1'b1;
        end else begin
          next_s = count_r - CNT_W'(1'b1);
        end
      end
      OP_ADD: begin
        if (sum_s[CNT_W]) begin
          next_s = '1;
          sat_s  = 1'b1;
        end else begin
          next_s = sum_s[CNT_W-1:0];
        end
      end
`else
      OP_INC:  next_s = count_r + CNT_W'(1'b1);
      OP_DEC:  next_s = count_r - CNT_W'(1'b1);
      OP_ADD:  next_s = sum_s[CNT_W-1:0];
`endif
      default: next_s = count_r;
    endcase
  end

  // Lane register, written only when this lane is addressed by a legal command
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (we) begin
      count_r <= next_s;
    end
  end

  assign next_count = next_s;
  assign sat        = sat_s;

endmodule

// File: rtl/case_lane_counter.sv
// Command-driven bank of per-lane counters with a valid/ready response port.
// Optional clamping arithmetic: define CASE_LANE_SAT_EN.
module case_lane_counter
  import case_lane_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_lane,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err,
  output logic             out_sat
);

  state_e             state_r, state_s;
  logic [OP_W-1:0]    op_r;
  logic [LANE_W-1:0]  lane_r;
  logic [OPND_W-1:0]  opnd_r;
  logic [15:0]        opnd_ext_s;
  logic [CNT_W-1:0]   operand_s;
  logic               lane_ok_s;
  logic               err_s;
  logic [CNT_W-1:0]   next_arr_s [NUM_LANES];
  logic [NUM_LANES-1:0] sat_vec_s;
  logic [NUM_LANES-1:0] we_s;
  logic [CNT_W-1:0]   sel_next_s;
  logic               sel_sat_s;
  logic               unused_word_s;

  assign unused_word_s = ^in_word[31:16];
  assign in_ready      = (state_r == ST_IDLE);

  // Zero-extend then cut to CNT_W: covers both truncation and extension
  assign opnd_ext_s = {8'h00, opnd_r};
  assign operand_s  = opnd_ext_s[CNT_W-1:0];
  assign lane_ok_s  = ({1'b0, lane_r} < 5'(NUM_LANES));
  assign err_s      = !op_legal(op_r) || !lane_ok_s;

  for (genvar i = 0; i < NUM_LANES; i++) begin : gen_lane
    assign we_s[i] = (state_r == ST_EXEC) && !err_s && (lane_r == 4'(i));
    case_lane_cell #(.CNT_W(CNT_W)) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .op         (op_r),
      .operand    (operand_s),
      .we         (we_s[i]),
      .next_count (next_arr_s[i]),
      .sat        (sat_vec_s[i])
    );
  end

  // Lane mux: pick the addressed lane's post-operation value and clamp flag
  always_comb begin
    sel_next_s = '0;
    sel_sat_s  = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      sel_next_s = (lane_r == 4'(i)) ? next_arr_s[i] : sel_next_s;
      sel_sat_s  = (lane_r == 4'(i)) ? sat_vec_s[i]  : sel_sat_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: state_s = in_valid  ? ST_EXEC : ST_IDLE;
      ST_EXEC: state_s = ST_RESP;
      ST_RESP: state_s = out_ready ? ST_IDLE : ST_RESP;
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Command capture; words offered outside IDLE are ignored
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_r   <= 4'd0;
      lane_r <= 4'd0;
      opnd_r <= 8'd0;
    end else if ((state_r == ST_IDLE) && in_valid) begin
      op_r   <= in_word[OP_LSB   +: OP_W];
      lane_r <= in_word[LANE_LSB +: LANE_W];
      opnd_r <= in_word[OPND_LSB +: OPND_W];
    end
  end

  // Response registers, loaded in EXEC and held until the beat is taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_lane  <= 4'd0;
      out_count <= '0;
      out_err   <= 1'b0;
      out_sat   <= 1'b0;
    end else if (state_r == ST_EXEC) begin
      out_valid <= 1'b1;
      out_lane  <= lane_r;
      out_count <= err_s ? '0 : sel_next_s;
      out_err   <= err_s;
      out_sat   <= !err_s && sel_sat_s;
    end else if ((state_r == ST_RESP) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
